// File: rtl/tester_pkg.sv
// Shared tester definitions: compare-mode encodings and strobe/cycle widths.
package tester_pkg;

    localparam int STROBE_W = 7;
    localparam int CYC_W    = 8;

    typedef enum logic [1:0] {
        CMP_MASK   = 2'b00,
        CMP_EDGE   = 2'b01,
        CMP_WINDOW = 2'b10,
        CMP_TOGGLE = 2'b11
    } cmp_mode_e;

    // Per-cycle compare setup, captured at tick 0 and held for the cycle.
    typedef struct packed {
        logic                exp;
        cmp_mode_e           mode;
        logic [STROBE_W-1:0] start;
        logic [STROBE_W-1:0] stop;
    } cycle_cfg_t;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer, both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is safe to use in the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pin_strobe_cmp.sv
// Per-pin strobe/compare receiver: samples the synchronized DUT pin over a
// programmed window in each tester cycle and keeps pass/fail bookkeeping.
module pin_strobe_cmp
    import tester_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [STROBE_W-1:0] STROBE_START,
    input  logic [STROBE_W-1:0] STROBE_END,
    input  logic [CYC_W-1:0]    CYCLE_LENGTH,
    input  logic                EXP,
    input  logic [1:0]          CMP_MODE,
    input  logic                CLR_FAIL,
    input  logic                DUT_IN,
    output logic                CYCLE_DONE,
    output logic                FAIL_PULSE,
    output logic                STICKY_FAIL,
    output logic [CNT_W-1:0]    FAIL_COUNT,
    output logic [CNT_W-1:0]    CYCLE_INDEX,
    output logic [CNT_W-1:0]    FIRST_FAIL_CYCLE,
    output logic                CFG_ERR
);

    logic             dut_s, prev_s;
    logic [CYC_W-1:0] t;
    cycle_cfg_t       cfg_q, cfg_live, cfg;
    logic [CYC_W-1:0] len_m1, start_x, stop_x, end_eff;
    logic             run, last, in_win, miss_now, tog_now;
    logic             miss_acc, tog_acc, seen_acc, cyc_fail;

    sync_2ff u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (DUT_IN),
        .q   (dut_s)
    );

    // Window decode and per-tick compare; tick 0 uses the live config since
    // the latched copy only becomes visible from tick 1 onward.
    always_comb begin
        CFG_ERR  = (CYCLE_LENGTH < 8'd2);
        run      = EN & ~CFG_ERR;
        len_m1   = CYCLE_LENGTH - 8'd1;
        cfg_live = '{exp: EXP, mode: cmp_mode_e'(CMP_MODE),
                     start: STROBE_START, stop: STROBE_END};
        cfg      = (t == '0) ? cfg_live : cfg_q;
        start_x  = {1'b0, cfg.start};
        stop_x   = {1'b0, cfg.stop};
        end_eff  = (stop_x < len_m1) ? stop_x : len_m1;
        in_win   = (t >= start_x) && (t <= end_eff);
        miss_now = 1'b0;
        case (cfg.mode)
            CMP_EDGE:   miss_now = in_win && (t == start_x) && (dut_s != cfg.exp);
            CMP_WINDOW: miss_now = in_win && (dut_s != cfg.exp);
            default:    miss_now = 1'b0;
        endcase
        tog_now  = in_win && (t > start_x) && (dut_s != prev_s);
        // An empty window never fails, even in toggle mode.
        if (cfg.mode == CMP_TOGGLE)
            cyc_fail = (seen_acc | in_win) & ~(tog_acc | tog_now);
        else
            cyc_fail = miss_acc | miss_now;
        // >= so that shrinking CYCLE_LENGTH mid-cycle ends the cycle at once.
        last     = run && (t >= len_m1);
    end

    // Tick counter, config latch and in-cycle accumulators.
    always_ff @(posedge CLK) begin
        if (RST) begin
            t        <= '0;
            cfg_q    <= '0;
            prev_s   <= 1'b0;
            miss_acc <= 1'b0;
            tog_acc  <= 1'b0;
            seen_acc <= 1'b0;
        end else begin
            prev_s <= dut_s;
            if (run && (t == '0))
                cfg_q <= cfg_live;
            if (!run || last) begin
                t        <= '0;
                miss_acc <= 1'b0;
                tog_acc  <= 1'b0;
                seen_acc <= 1'b0;
            end else begin
                t        <= t + 8'd1;
                miss_acc <= miss_acc | miss_now;
                tog_acc  <= tog_acc  | tog_now;
                seen_acc <= seen_acc | in_win;
            end
        end
    end

    // End-of-cycle results; a clear coinciding with a fail is applied first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CYCLE_DONE       <= 1'b0;
            FAIL_PULSE       <= 1'b0;
            STICKY_FAIL      <= 1'b0;
            FAIL_COUNT       <= '0;
            CYCLE_INDEX      <= '0;
            FIRST_FAIL_CYCLE <= '0;
        end else begin
            CYCLE_DONE <= last;
            FAIL_PULSE <= last && cyc_fail;
            if (last)
                CYCLE_INDEX <= CYCLE_INDEX + CNT_W'(1);
            if (last && cyc_fail) begin
                STICKY_FAIL <= 1'b1;
                if (CLR_FAIL)
                    FAIL_COUNT <= CNT_W'(1);
                else if (FAIL_COUNT != '1)
                    FAIL_COUNT <= FAIL_COUNT + CNT_W'(1);
                if (CLR_FAIL || !STICKY_FAIL)
                    FIRST_FAIL_CYCLE <= CYCLE_INDEX;
            end else if (CLR_FAIL) begin
                STICKY_FAIL      <= 1'b0;
                FAIL_COUNT       <= '0;
                FIRST_FAIL_CYCLE <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pin_strobe_cmp.sv
// Bench for pin_strobe_cmp: cycle-level model plus directed scenarios.
module tb_pin_strobe_cmp;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          exp_lv = 1'b1;
    logic          clr = 1'b0;
    logic          din = 1'b1;
    logic [6:0]    ss = 7'd5;
    logic [6:0]    se = 7'd10;
    logic [7:0]    cl = 8'd15;
    logic [1:0]    mode = 2'b10;
    logic          done, fp, sticky, cerr;
    logic [CW-1:0] fcnt, cidx, ffc;

    pin_strobe_cmp #(.CNT_W(CW)) dut (
        .CLK(clk), .RST(rst), .EN(en),
        .STROBE_START(ss), .STROBE_END(se), .CYCLE_LENGTH(cl),
        .EXP(exp_lv), .CMP_MODE(mode), .CLR_FAIL(clr), .DUT_IN(din),
        .CYCLE_DONE(done), .FAIL_PULSE(fp), .STICKY_FAIL(sticky),
        .FAIL_COUNT(fcnt), .CYCLE_INDEX(cidx), .FIRST_FAIL_CYCLE(ffc),
        .CFG_ERR(cerr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- cycle-level model ----------------
    int m_t = 0;
    int m_samp[256];
    int m_exp, m_mode, m_ss, m_se;
    int e_done = 0, e_fp = 0, e_sticky = 0, e_cnt = 0, e_idx = 0, e_first = 0;
    bit dq[$] = '{1'b0, 1'b0};

    // Judge a finished cycle from the full list of samples taken in it.
    function automatic int eval_cycle(input int len);
        int lst;
        lst = (m_se < len - 1) ? m_se : len - 1;
        if (m_ss > lst) return 0;
        case (m_mode)
            1: return (m_samp[m_ss] != m_exp) ? 1 : 0;
            2: begin
                for (int i = m_ss; i <= lst; i++)
                    if (m_samp[i] != m_exp) return 1;
                return 0;
            end
            3: begin
                for (int i = m_ss + 1; i <= lst; i++)
                    if (m_samp[i] != m_samp[i-1]) return 0;
                return 1;
            end
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit s;
        int f;
        dq.push_back(rst ? 1'b0 : din);
        s = dq[dq.size()-3];
        if (dq.size() > 3) void'(dq.pop_front());
        e_done = 0;
        e_fp   = 0;
        if (rst) begin
            m_t = 0; e_sticky = 0; e_cnt = 0; e_idx = 0; e_first = 0;
        end else begin
            if (clr) begin e_sticky = 0; e_cnt = 0; e_first = 0; end
            if (!en || cl < 2) begin
                m_t = 0;
            end else begin
                if (m_t == 0) begin
                    m_exp = exp_lv; m_mode = mode; m_ss = ss; m_se = se;
                end
                m_samp[m_t] = s;
                if (m_t >= int'(cl) - 1) begin
                    f = eval_cycle(int'(cl));
                    e_done = 1;
                    e_fp   = f;
                    if (f != 0) begin
                        if (e_sticky == 0) e_first = e_idx;
                        e_sticky = 1;
                        if (e_cnt < MAXC) e_cnt++;
                    end
                    e_idx = (e_idx + 1) % (MAXC + 1);
                    m_t = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_done",   done,   e_done);
        chk("m_fail",   fp,     e_fp);
        chk("m_sticky", sticky, e_sticky);
        chk("m_count",  fcnt,   e_cnt);
        chk("m_index",  cidx,   e_idx);
        chk("m_first",  ffc,    e_first);
        chk("m_cfgerr", cerr,   (cl < 2) ? 1 : 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One 15-clock cycle; optionally drop DUT_IN so the sample at T=7 is 0.
    task automatic run_cycle(input bit glitch);
        if (glitch) begin
            tick(5); din = 1'b0; tick(1); din = 1'b1; tick(9);
        end else begin
            tick(15);
        end
    endtask

    task automatic toggle_cycle();
        for (int k = 0; k < 15; k++) begin
            din = ((k >> 1) & 1) != 0;
            tick(1);
        end
        din = 1'b1;
    endtask

    initial begin
        tick(3);
        chk("rst_done", done, 0);
        chk("rst_count", fcnt, 0);
        chk("rst_index", cidx, 0);
        rst = 1'b0; en = 1'b1;

        tick(45);
        chk("pass_index", cidx, 3);
        chk("pass_count", fcnt, 0);
        chk("pass_done", done, 1);

        run_cycle(1'b1);
        chk("win_fail", fp, 1);
        chk("win_count", fcnt, 1);
        chk("win_first", ffc, 3);
        chk("win_sticky", sticky, 1);

        mode = 2'b01;
        run_cycle(1'b1);
        chk("edge_pass", fp, 0);
        chk("edge_count", fcnt, 1);

        mode = 2'b11;
        toggle_cycle();
        chk("tog_pass", fp, 0);
        din = 1'b1;
        tick(15);
        chk("tog_const_fail", fp, 1);
        chk("tog_const_count", fcnt, 2);
        ss = 7'd5; se = 7'd5;
        toggle_cycle();
        chk("tog_single_fail", fp, 1);
        chk("tog_single_count", fcnt, 3);

        // Abandon a cycle by dropping EN at T=8.
        mode = 2'b00; se = 7'd10;
        tick(8); en = 1'b0;
        tick(5);
        chk("en_low_done", done, 0);
        chk("en_low_index", cidx, 8);
        en = 1'b1;
        tick(14);
        chk("en_early_done", done, 0);
        tick(1);
        chk("en_done", done, 1);
        chk("en_index", cidx, 9);

        // Clear arriving with a failing end-of-cycle.
        mode = 2'b11; din = 1'b1;
        tick(14); clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_count", fcnt, 1);
        chk("clr_first", ffc, 9);
        chk("clr_sticky", sticky, 1);

        repeat (20) tick(15);
        chk("sat_count", fcnt, MAXC);

        mode = 2'b10; exp_lv = 1'b1; din = 1'b0; ss = 7'd12; se = 7'd4;
        tick(15);
        chk("empty_pass", fp, 0);
        chk("empty_done", done, 1);

        cl = 8'd1;
        tick(1);
        chk("len1_cfgerr", cerr, 1);
        tick(20);
        chk("len1_done", done, 0);
        chk("len1_index", cidx, 15);
        cl = 8'd15;

        tick(6); rst = 1'b1; tick(1);
        chk("mrst_count", fcnt, 0);
        chk("mrst_sticky", sticky, 0);
        chk("mrst_index", cidx, 0);
        chk("mrst_first", ffc, 0);
        rst = 1'b0;
        tick(15);
        chk("post_rst_index", cidx, 1);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pin_strobe_cmp.md
# pin_strobe_cmp

Per-pin compare/strobe receiver for the ASIC tester: the receive-side counterpart of the pin drive formatter. Within each tester cycle it samples the DUT output at a programmed strobe point or window and checks it against the expected level or a toggle requirement. It reports a pass/fail per cycle and keeps a sticky fail flag, a saturating fail count and the index of the first failing cycle. The timing generator sits beside it, and the pattern sequencer reads its results.

## Interface

Parameters:

- CNT_W, 16: width of FAIL_COUNT, CYCLE_INDEX and FIRST_FAIL_CYCLE.

Ports:

- CLK  in  1  tester clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run enable; cycles advance only while high.
- STROBE_START  in  7  first sample tick of the window.
- STROBE_END  in  7  last sample tick of the window, inclusive.
- CYCLE_LENGTH  in  8  tester-cycle length in clocks; legal range 2..255.
- EXP  in  1  expected DUT level for this cycle.
- CMP_MODE  in  2  compare mode:
  - 00 MASK
  - 01 EDGE
  - 10 WINDOW
  - 11 TOGGLE
- CLR_FAIL  in  1  clears STICKY_FAIL, FAIL_COUNT and FIRST_FAIL_CYCLE.
- DUT_IN  in  1  asynchronous DUT pin level.
- CYCLE_DONE  out  1  one-clock pulse at the end of each completed cycle.
- FAIL_PULSE  out  1  high with CYCLE_DONE when that cycle failed.
- STICKY_FAIL  out  1  set by any failing cycle.
- FAIL_COUNT  out  CNT_W  number of failing cycles; saturates at all-ones.
- CYCLE_INDEX  out  CNT_W  count of completed cycles since reset; wraps.
- FIRST_FAIL_CYCLE  out  CNT_W  CYCLE_INDEX value of the first failing cycle.
- CFG_ERR  out  1  high while CYCLE_LENGTH < 2.

## Operation

- DUT_IN passes through a 2-flop synchronizer; all compares use the synchronized value.
- The tick counter T runs 0..CYCLE_LENGTH-1 while EN is high and CFG_ERR is low, then wraps to 0.
- At T=0 the block latches EXP, CMP_MODE, STROBE_START and STROBE_END; they are held for the whole cycle.
- The effective end is min(STROBE_END, CYCLE_LENGTH-1). If STROBE_START is greater than the effective end, the window is empty and the cycle passes.
- Compare modes:
  - MASK: the cycle always passes.
  - EDGE: the cycle fails if the sample at T == STROBE_START differs from EXP.
  - WINDOW: the cycle fails if any sample with STROBE_START ≤ T ≤ end differs from EXP.
  - TOGGLE: the cycle fails unless the synchronized level changes at least once between consecutive samples inside the window. EXP is ignored. A single-tick window always fails.
- End of cycle:
  - CYCLE_DONE pulses.
  - FAIL_PULSE shows the cycle result.
  - CYCLE_INDEX increments.
  - On a failing cycle, FAIL_COUNT increments (saturating) and STICKY_FAIL sets. If STICKY_FAIL was previously clear, FIRST_FAIL_CYCLE captures the pre-increment CYCLE_INDEX.
- EN falling mid-cycle abandons the cycle: T returns to 0, there is no CYCLE_DONE, and the partial result is discarded. When EN rises again, a fresh cycle starts at T=0.
- CFG_ERR high behaves like EN low.
- CLR_FAIL coinciding with a failing CYCLE_DONE: the clear applies first, then the new fail is recorded. Result: FAIL_COUNT=1, STICKY_FAIL=1, FIRST_FAIL_CYCLE equals that cycle's index.

## Timing

- Reset: every output is 0, T=0, both synchronizer flops are 0, and the latched configuration is 0 (MASK).
- Synchronizer latency is 2 clocks: the sample at tick T reflects DUT_IN as captured at tick T-2. Strobe settings are programmed in synchronized time; the 2-clock offset is software's responsibility.
- CYCLE_DONE and FAIL_PULSE are registered and appear the clock after the T = CYCLE_LENGTH-1 tick. They overlap T=0 of the next cycle when EN stays high.
- STICKY_FAIL, FAIL_COUNT, CYCLE_INDEX and FIRST_FAIL_CYCLE update on the same edge as CYCLE_DONE.
- CLR_FAIL takes effect on the next edge.
- RST asserted mid-cycle forces reset values on the next edge, with no CYCLE_DONE.
- Changing CYCLE_LENGTH mid-cycle: the new value is used for the wrap compare immediately. If T is already at or above the new CYCLE_LENGTH-1, the cycle ends at once.

## Structure

- Shared package `tester_pkg`: CMP_MODE encodings (CMP_MASK, CMP_EDGE, CMP_WINDOW, CMP_TOGGLE) and the strobe/cycle width constants (7 and 8), shared with the drive formatter.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer reset to 0, reused later for other pin inputs.
- The tick counter, window compare and result registers stay in the top level.

## Test plan

- Pass case:
  - Setup: CYCLE_LENGTH=15, STROBE 5..10, WINDOW, EXP=1, DUT_IN held 1.
  - Response: CYCLE_DONE every 15 clocks, FAIL_PULSE=0, FAIL_COUNT=0, CYCLE_INDEX=1,2,3….
- Window vs edge detection:
  - Setup: same as the pass case, with DUT_IN pulsed to 0 for one clock so the synchronized sample at T=7 is 0.
  - WINDOW response: FAIL_PULSE=1, FAIL_COUNT=1, FIRST_FAIL_CYCLE equals that cycle's index.
  - Same stimulus in EDGE mode: passes.
- TOGGLE mode:
  - DUT_IN toggling every 2 clocks: passes.
  - DUT_IN constant: fails every cycle.
  - STROBE 5..5 (single tick): always fails.
- EN low at T=8: no CYCLE_DONE and no counter change; after EN high, the next CYCLE_DONE comes 15 clocks later.
- Saturation and clear:
  - With CNT_W=4, 20 consecutive failing cycles give FAIL_COUNT=15.
  - CLR_FAIL coincident with a failing CYCLE_DONE gives FAIL_COUNT=1.
- Configuration boundaries:
  - CYCLE_LENGTH=1: CFG_ERR=1, no CYCLE_DONE.
  - STROBE 12..4: every cycle passes.
  - RST mid-cycle: all outputs return to 0 on the next clock.
